// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier: one carry-lookahead addition per clock,
// exact 2*NBIT-bit product NBIT cycles after start is accepted.

module carry_lookahead_adder #(
    parameter int NBIT = 32
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    output logic [NBIT-1:0] sum,
    output logic            cout
);
    localparam int NGRP = (NBIT + 3) / 4;

    logic [NBIT-1:0] g;
    logic [NBIT-1:0] pr;
    logic [NBIT:0]   c;
    logic [NGRP:0]   cg;
    logic [NGRP-1:0] gg;
    logic [NGRP-1:0] gp;

    assign g  = a & b;
    assign pr = a ^ b;

    // 4-bit lookahead groups; group carries chain through group generate/propagate.
    always_comb begin
        logic t;
        logic prod;
        gg = '0;
        gp = '0;
        cg = '0;
        c  = '0;
        for (int k = 0; k < NGRP; k++) begin
            t    = 1'b0;
            prod = 1'b1;
            for (int j = ((k * 4 + 3 < NBIT) ? k * 4 + 3 : NBIT - 1); j >= k * 4; j--) begin
                t    = t | (g[j] & prod);
                prod = prod & pr[j];
            end
            gg[k]   = t;
            gp[k]   = prod;
            cg[k+1] = gg[k] | (gp[k] & cg[k]);
        end
        for (int i = 0; i < NBIT; i++) begin
            t    = 1'b0;
            prod = 1'b1;
            for (int j = i; j >= (i / 4) * 4; j--) begin
                t    = t | (g[j] & prod);
                prod = prod & pr[j];
            end
            c[i+1] = t | (prod & cg[i/4]);
        end
    end

    assign sum  = pr ^ c[NBIT-1:0];
    assign cout = cg[NGRP];
endmodule

module shift_add_multiplier #(
    parameter int NBIT = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [2*NBIT-1:0] p
);
    localparam int CW = $clog2(NBIT);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [NBIT-1:0] mcand;
    logic [NBIT-1:0] acc;
    logic [NBIT-1:0] mq;
    logic [CW-1:0]   cnt;
    logic [NBIT-1:0] addend;
    logic [NBIT-1:0] sum;
    logic            cout;

    assign addend = mq[0] ? mcand : '0;

    carry_lookahead_adder #(.NBIT(NBIT)) u_cla (
        .a    (acc),
        .b    (addend),
        .sum  (sum),
        .cout (cout)
    );

    // Handshake: start is taken only while busy is low; busy stays high from the
    // accepting edge through the single done cycle, and start is ignored meanwhile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            p     <= '0;
            mcand <= '0;
            acc   <= '0;
            mq    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        mq    <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= {cout, sum[NBIT-1:1]};
                    mq  <= {sum[0], mq[NBIT-1:1]};
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NBIT - 1)) begin
                        p     <= {cout, sum, mq[NBIT-1:1]};
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier at NBIT=4 and NBIT=32: directed boundaries,
// ignore/reset rules and a start-held random regression against a*b.

module tb_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        rst4, rst32;
    logic        start4, start32;
    logic [3:0]  a4, b4;
    logic [31:0] a32, b32;
    logic        busy4, done4, busy32, done32;
    logic [7:0]  p4;
    logic [63:0] p32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.NBIT(4)) u_dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .p(p4)
    );

    shift_add_multiplier #(.NBIT(32)) u_dut32 (
        .clk(clk), .rst(rst32), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .p(p32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic obs_busy(input int n);
        return (n == 4) ? busy4 : busy32;
    endfunction

    function automatic logic obs_done(input int n);
        return (n == 4) ? done4 : done32;
    endfunction

    function automatic logic [63:0] obs_p(input int n);
        return (n == 4) ? {56'd0, p4} : p32;
    endfunction

    task automatic drive(input int n, input logic st, input logic [31:0] aa, input logic [31:0] bb);
        if (n == 4) begin
            start4 = st; a4 = aa[3:0]; b4 = bb[3:0];
        end else begin
            start32 = st; a32 = aa; b32 = bb;
        end
    endtask

    // One operation: accept, scramble inputs every cycle, optional stray start at cycle 10.
    task automatic run_op(input int n, input logic [31:0] aa, input logic [31:0] bb,
                          input bit inject, input string tag);
        logic [63:0] expp;
        int lat, pulses, busy_cyc;
        expp = 64'(aa) * 64'(bb);
        lat = -1; pulses = 0; busy_cyc = 1;
        @(negedge clk);
        drive(n, 1'b1, aa, bb);
        @(negedge clk);
        check({tag, "_busy_after_accept"}, 64'(obs_busy(n)), 64'd1);
        check({tag, "_done_after_accept"}, 64'(obs_done(n)), 64'd0);
        drive(n, 1'b0, $urandom, $urandom);
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clk);
            if (obs_done(n)) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (obs_busy(n)) busy_cyc++;
            if (inject && k == 10) drive(n, 1'b1, 32'd100, 32'd100);
            else drive(n, 1'b0, $urandom, $urandom);
        end
        check({tag, "_latency"}, 64'(lat), 64'(n));
        check({tag, "_done_pulses"}, 64'(pulses), 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(n + 1));
        check({tag, "_product"}, obs_p(n), expp);
    endtask

    // start held high: accepts land every n+2 edges; results come back in order.
    task automatic rand_regress(input int n);
        logic [63:0] exp_q[$];
        logic [63:0] e;
        logic [31:0] ra, rb;
        int period, pulses;
        period = n + 2;
        pulses = 0;
        for (int t = 0; t <= 16 * period + 3; t++) begin
            @(negedge clk);
            if (t > 0 && obs_done(n)) begin
                pulses++;
                check($sformatf("rand%0d_phase", n), 64'((t - 1) % period), 64'(n));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("rand%0d_p", n), obs_p(n), e);
                    $display("rand%0d #%0d p=%0h exp=%0h %s", n, pulses, obs_p(n), e,
                             (obs_p(n) === e) ? "OK" : "NG");
                end else begin
                    check($sformatf("rand%0d_extra_done", n), 64'd1, 64'd0);
                end
            end
            if (t % period == 0 && t / period < 16) begin
                ra = (n == 4) ? $urandom_range(0, 15) : $urandom;
                rb = (n == 4) ? $urandom_range(0, 15) : $urandom;
                exp_q.push_back(64'(ra) * 64'(rb));
                drive(n, 1'b1, ra, rb);
            end else if (t == 16 * period) begin
                drive(n, 1'b0, 32'd0, 32'd0);
            end
        end
        check($sformatf("rand%0d_pulses", n), 64'(pulses), 64'd16);
        check($sformatf("rand%0d_queue_left", n), 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int pulses;
        rst4 = 1'b0; rst32 = 1'b0;
        drive(4, 1'b0, 32'd0, 32'd0);
        drive(32, 1'b0, 32'd0, 32'd0);
        #1;
        rst4 = 1'b1; rst32 = 1'b1;

        // Reset held with random inputs and start asserted.
        for (int i = 0; i < 3; i++) begin
            drive(4, 1'b1, $urandom, $urandom);
            drive(32, 1'b1, $urandom, $urandom);
            @(negedge clk);
            check("rst_busy4", 64'(busy4), 64'd0);
            check("rst_done4", 64'(done4), 64'd0);
            check("rst_p4", 64'(p4), 64'd0);
            check("rst_busy32", 64'(busy32), 64'd0);
            check("rst_done32", 64'(done32), 64'd0);
            check("rst_p32", p32, 64'd0);
        end
        drive(4, 1'b0, 32'd0, 32'd0);
        drive(32, 1'b0, 32'd0, 32'd0);
        rst4 = 1'b0; rst32 = 1'b0;

        run_op(4, 32'd15, 32'd15, 1'b0, "n4_15x15");
        run_op(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "n32_max");
        check("n32_max_literal", p32, 64'hFFFF_FFFE_0000_0001);
        run_op(32, 32'd0, 32'd12345, 1'b0, "n32_zero");
        run_op(32, 32'd1, 32'h8000_0000, 1'b0, "n32_msb");
        check("n32_msb_literal", p32, 64'h0000_0000_8000_0000);
        run_op(32, 32'd3, 32'd5, 1'b1, "n32_ignore");

        // Abort mid-CALC with an asynchronous reset between edges.
        @(negedge clk);
        drive(32, 1'b1, 32'd1000, 32'd1000);
        @(negedge clk);
        drive(32, 1'b0, $urandom, $urandom);
        repeat (3) @(negedge clk);
        #2 rst32 = 1'b1;
        #1;
        check("midrst_busy", 64'(busy32), 64'd0);
        check("midrst_done", 64'(done32), 64'd0);
        check("midrst_p", p32, 64'd0);
        @(negedge clk);
        rst32 = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done32) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'd0);
        check("midrst_idle", 64'(busy32), 64'd0);
        run_op(32, 32'd7, 32'd6, 1'b0, "post_rst");

        rand_regress(4);
        rand_regress(32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
